// File: rtl/aes_pkg.sv
// Shared types and constants for the AES session controller.
package aes_pkg;

   localparam int unsigned AES_BLOCK_W           = 128;
   localparam int unsigned AES_SCHED_TIMEOUT_DEF = 63;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_KEY,
      S_WAIT_DATA,
      S_ISSUE,
      S_BUSY,
      S_WRITE,
      S_DONE,
      S_ERROR
   } aes_sched_state_t;

endpackage

// File: rtl/aes_sched_if.sv
// Command, FIFO and datapath handshake bundle around the AES session controller.
interface aes_sched_if #(
   parameter int unsigned CNT_W = 16
);

   logic             start;
   logic             abort;
   logic             mode_encrypt;
   logic [CNT_W-1:0] num_blocks;
   logic             key_ready;
   logic             rx_fifo_empty;
   logic             tx_fifo_full;
   logic             aes_data_done;
   logic             aes_data_valid;
   logic             read_fifo;
   logic             is_encrypt;
   logic             tx_push;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] blocks_left;

   // Environment side: command logic, FIFOs and datapath.
   modport master (
      output start, abort, mode_encrypt, num_blocks, key_ready,
             rx_fifo_empty, tx_fifo_full, aes_data_done, aes_data_valid,
      input  read_fifo, is_encrypt, tx_push, busy, done, error, blocks_left
   );

   // Controller side.
   modport slave (
      input  start, abort, mode_encrypt, num_blocks, key_ready,
             rx_fifo_empty, tx_fifo_full, aes_data_done, aes_data_valid,
      output read_fifo, is_encrypt, tx_push, busy, done, error, blocks_left
   );

endinterface

// File: rtl/aes_sched_wdog.sv
// Clearable, enable-gated watchdog counter; expired flags the cycle whose tick reaches TIMEOUT.
module aes_sched_wdog #(
   parameter int unsigned TIMEOUT = 63
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT + 1);

   logic [W-1:0] count;

   // clr together with en counts the clearing cycle itself as the first tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= en ? W'(1) : '0;
      end else if (en && (count != W'(TIMEOUT))) begin
         count <= count + W'(1);
      end
   end

   assign expired = en && (({1'b0, count} + (W+1)'(1)) >= (W+1)'(TIMEOUT));

endmodule

// File: rtl/aes_sched.sv
// AES session controller: sequences key/RX/datapath/TX handshakes for a block-count session.
module aes_sched
   import aes_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = AES_SCHED_TIMEOUT_DEF
) (
   input logic        clk,
   input logic        rst,
   aes_sched_if.slave bus
);

   aes_sched_state_t state, state_next;
   logic [CNT_W-1:0] blocks_left_q, blocks_left_next;
   logic             is_encrypt_q, is_encrypt_next;
   logic             wdog_clr, wdog_en, wdog_expired;

   aes_sched_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (wdog_clr),
      .en      (wdog_en),
      .expired (wdog_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         blocks_left_q <= '0;
         is_encrypt_q  <= 1'b0;
      end else begin
         state         <= state_next;
         blocks_left_q <= blocks_left_next;
         is_encrypt_q  <= is_encrypt_next;
      end
   end

   always_comb begin
      state_next       = state;
      blocks_left_next = blocks_left_q;
      is_encrypt_next  = is_encrypt_q;
      wdog_clr         = 1'b0;
      wdog_en          = 1'b0;
      bus.read_fifo    = 1'b0;
      bus.tx_push      = 1'b0;
      bus.done         = 1'b0;

      // Abort overrides every transition and suppresses the strobes of the current cycle.
      if (bus.abort) begin
         state_next = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE, S_ERROR: begin
               if (bus.start) begin
                  is_encrypt_next  = bus.mode_encrypt;
                  blocks_left_next = bus.num_blocks;
                  state_next       = (bus.num_blocks != '0) ? S_WAIT_KEY : S_DONE;
               end
            end
            S_WAIT_KEY: begin
               if (bus.key_ready) state_next = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
               if (!bus.rx_fifo_empty) state_next = S_ISSUE;
            end
            S_ISSUE: begin
               bus.read_fifo = 1'b1;
               wdog_clr      = 1'b1;
               wdog_en       = 1'b1;
               state_next    = S_BUSY;
            end
            S_BUSY: begin
               wdog_en = 1'b1;
               if (bus.aes_data_done) begin
                  state_next = bus.aes_data_valid ? S_WRITE : S_ERROR;
               end else if (wdog_expired) begin
                  state_next = S_ERROR;
               end
            end
            S_WRITE: begin
               if (!bus.tx_fifo_full) begin
                  bus.tx_push      = 1'b1;
                  blocks_left_next = blocks_left_q - CNT_W'(1);
                  state_next       = (blocks_left_q == CNT_W'(1)) ? S_DONE : S_WAIT_DATA;
               end
            end
            S_DONE: begin
               bus.done   = 1'b1;
               state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   assign bus.busy        = (state == S_WAIT_KEY) || (state == S_WAIT_DATA) ||
                            (state == S_ISSUE) || (state == S_BUSY) || (state == S_WRITE);
   assign bus.error       = (state == S_ERROR);
   assign bus.is_encrypt  = is_encrypt_q;
   assign bus.blocks_left = blocks_left_q;

endmodule

// File: doc/aes_sched.md
# aes_sched

Session controller for the AES datapath block. It accepts a start command with a block count and a mode, and latches the mode onto the datapath's `is_encrypt` select. For each 128-bit block it waits for an expanded key and RX data, issues the one-cycle `read_fifo` pulse, waits for the datapath's `data_done`/`data_valid`, and pushes the result into the TX FIFO under backpressure. It sits between the top-level command logic, the RX/TX FIFOs and the AES block, and reports busy, done and timeout error.

## Interface
- `CNT_W`, 16: width of block count.
- `TIMEOUT`, 63: maximum cycles spent in BUSY before an error is raised; must be ≥ 1.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: session start pulse; honoured only in IDLE or ERROR.
- `abort` in 1: cancels the session; state goes to IDLE next cycle and no `done` pulse is produced.
- `mode_encrypt` in 1: sampled with `start`; 1 selects encrypt, 0 selects decrypt.
- `num_blocks` in CNT_W: sampled with `start`; the number of blocks in the session.
- `key_ready` in 1: round-key memory is fully expanded.
- `rx_fifo_empty` in 1: RX FIFO has no block available.
- `tx_fifo_full` in 1: TX FIFO cannot accept a block.
- `aes_data_done` in 1: datapath has finished the current block.
- `aes_data_valid` in 1: datapath output is valid.
- `read_fifo` out 1: one-cycle pulse; pops the RX FIFO and starts the datapath.
- `is_encrypt` out 1: latched mode select driven to the datapath.
- `tx_push` out 1: write strobe to the TX FIFO.
- `busy` out 1: a session is in progress.
- `done` out 1: one-cycle pulse at the end of a session.
- `error` out 1: sticky timeout or protocol error flag.
- `blocks_left` out CNT_W: number of blocks remaining in the session.

## Operation
- States: IDLE, WAIT_KEY, WAIT_DATA, ISSUE, BUSY, WRITE, DONE, ERROR.
- IDLE or ERROR with `start`:
  - Clear `error`, latch `is_encrypt` from `mode_encrypt`, load `blocks_left` from `num_blocks`.
  - If `num_blocks` is nonzero, go to WAIT_KEY. If `num_blocks` is 0, go to DONE.
- WAIT_KEY: when `key_ready`, go to WAIT_DATA.
- WAIT_DATA: when `!rx_fifo_empty`, go to ISSUE.
- ISSUE: `read_fifo` = 1 for exactly this cycle; clear the watchdog; go to BUSY.
- BUSY:
  - `aes_data_done` with `aes_data_valid`: go to WRITE.
  - `aes_data_done` without `aes_data_valid`: protocol error, go to ERROR.
  - Watchdog increments each cycle; when it reaches TIMEOUT, go to ERROR.
- WRITE:
  - `tx_push` = `!tx_fifo_full` (Mealy output). While full, hold in WRITE.
  - On a push, `blocks_left` decrements. If `blocks_left` was 1, go to DONE; otherwise go to WAIT_DATA.
- DONE: `done` = 1 for one cycle; go to IDLE.
- ERROR: `error` = 1 and holds until `start` or `rst`.
- `abort` takes priority over every transition except `rst`. The target is IDLE; `error` is cleared and `blocks_left` is held.
- `start` is ignored in all states other than IDLE and ERROR. `is_encrypt` never changes mid-session.
- `busy` = 1 in WAIT_KEY, WAIT_DATA, ISSUE, BUSY and WRITE.
- `key_ready` is sampled only in WAIT_KEY; a drop after that point does not stall the session.

## Timing
- Reset values: state IDLE, all outputs 0, `is_encrypt` 0, `blocks_left` 0, watchdog 0.
- `start` at cycle 0 with `key_ready` = 1 and RX non-empty:
  - WAIT_KEY at cycle 1, WAIT_DATA at cycle 2, `read_fifo` at cycle 3.
- Datapath done at cycle N: `tx_push` at cycle N+1 if not full.
- Minimum per-block overhead is 4 controller cycles plus datapath latency.
- `read_fifo` is never asserted twice without an intervening WRITE.
- `rst` in any state returns the block to the reset values on the next edge. In-flight data is dropped.
- Simultaneous `aes_data_done` and watchdog expiry: the done/valid result wins.

## Structure
- Shared package `aes_pkg` holds:
  - `aes_sched_state_t`, the 3-bit state enum.
  - `AES_SCHED_TIMEOUT_DEF`, the default TIMEOUT.
  - `AES_BLOCK_W` = 128.
- One sub-module, `aes_sched_wdog`:
  - Clearable, enable-gated up-counter sized by `$clog2(TIMEOUT+1)`.
  - Output `expired`.
- The FSM, mode latch and block counter stay in `aes_sched`.

## Test plan
- Basic session: `num_blocks` = 3, encrypt, key and RX ready, datapath done 12 cycles after each `read_fifo`.
  - Expect 3 `read_fifo` pulses, 3 `tx_push` pulses and one `done`.
  - `is_encrypt` = 1 throughout; `blocks_left` steps 3→2→1→0.
- Backpressure: `tx_fifo_full` held for 5 cycles in WRITE.
  - `tx_push` stays 0 and the block holds in WRITE for those cycles.
  - Push occurs on the first not-full cycle; `blocks_left` decrements once.
- Zero blocks: `start` with `num_blocks` = 0.
  - `done` pulses at cycle 1; no `read_fifo`; `busy` never asserts.
- Timeout: TIMEOUT = 63, datapath never signals done.
  - `error` = 1 exactly 63 cycles after ISSUE, and stays set.
  - A new `start` clears `error` and latches the new mode (decrypt → `is_encrypt` = 0).
- Abort and reset: `abort` in BUSY → IDLE next cycle, no `done`.
  - `rst` asserted mid-WRITE with full TX FIFO → all outputs 0 next cycle.
  - `start` is ignored while `busy`.
- Protocol error: `aes_data_done` = 1 with `aes_data_valid` = 0 in BUSY → ERROR with no `tx_push`.
